// File: rtl/system_pkg.sv
// System-wide constants and types shared by the Ibex data-side AHB-Lite bridge.
//   ADDR_WIDTH / DATA_WIDTH : bus widths (only a 32-bit data path is supported)
//   htrans_e                : AHB-Lite HTRANS encodings used by a single-transfer master
//   HSIZE_*                 : AHB-Lite HSIZE encodings for byte/half/word transfers
//   bridge_state_e          : bridge FSM states
package system_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    // Non-cacheable, non-bufferable, privileged data access.
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE, // no data phase outstanding
        ST_DATA, // one bus data phase outstanding
        ST_ERR2, // first ERROR cycle seen, waiting for the second
        ST_LERR  // illegal byte enable granted, local error pending
    } bridge_state_e;

endpackage

// File: rtl/ibex_ahbl_be_decode.sv
// Byte-enable to AHB-Lite size/low-address decode (purely combinational).
//   be      in  4 : Ibex byte enables
//   hsize   out 3 : AHB HSIZE for the enabled lanes
//   addr_lo out 2 : HADDR[1:0] of the lowest enabled lane
//   legal   out 1 : pattern is a naturally aligned byte, half or word
module ibex_ahbl_be_decode
    import system_pkg::*;
(
    input  logic [3:0] be,
    output logic [2:0] hsize,
    output logic [1:0] addr_lo,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        hsize   = HSIZE_BYTE;
        addr_lo = 2'b00;
        legal   = 1'b1;
        unique case (be)
            4'b1111: hsize = HSIZE_WORD;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
            4'b0001: addr_lo = 2'b00;
            4'b0010: addr_lo = 2'b01;
            4'b0100: addr_lo = 2'b10;
            4'b1000: addr_lo = 2'b11;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ibex_ahbl_bridge.sv
// Ibex data-memory (req/gnt/rvalid) to AHB-Lite single-transfer master bridge.
//   clk, rstn          : clock, asynchronous active-low reset
//   data_*             : Ibex LSU interface (req held stable until gnt,
//                        one rvalid per gnt, err qualified by rvalid)
//   ahbl_* outputs     : AHB-Lite master address/control and write data
//   ahbl_hrdata/hready/hresp : AHB-Lite slave response
// The address phase is combinational from the data_* inputs; HWDATA comes
// from a register loaded at grant and held through the data phase.
// Compile-time option IBEX_AHBL_PIPELINE_EN: when defined, a new address
// phase may overlap the current data phase, giving one transfer per cycle
// against a zero-wait slave. When undefined, issue happens only from IDLE.
module ibex_ahbl_bridge #(
    parameter int ADDR_WIDTH = system_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = system_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] ahbl_haddr,
    output logic [2:0]            ahbl_hburst,
    output logic                  ahbl_hmastlock,
    output logic [3:0]            ahbl_hprot,
    output logic [2:0]            ahbl_hsize,
    output logic [1:0]            ahbl_htrans,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata,
    output logic                  ahbl_hwrite,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
    input  logic                  ahbl_hready,
    input  logic                  ahbl_hresp
);

    import system_pkg::*;

    bridge_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;

    logic [2:0] be_hsize;
    logic [1:0] be_addr_lo;
    logic       be_legal;
    logic       issue_ok;

    // Requests are word aligned; the low address bits come from the byte enables.
    logic unused_addr_lo;
    assign unused_addr_lo = ^data_addr_i[1:0];

    ibex_ahbl_be_decode u_be_decode (
        .be      (data_be_i),
        .hsize   (be_hsize),
        .addr_lo (be_addr_lo),
        .legal   (be_legal)
    );

    // An ERROR response in the data phase blocks issue so the following
    // transfer is not presented during the two-cycle ERROR sequence.
`ifdef IBEX_AHBL_PIPELINE_EN
    assign issue_ok = (state_q == ST_IDLE) || ((state_q == ST_DATA) && !ahbl_hresp);
`else
    assign issue_ok = (state_q == ST_IDLE);
`endif

    assign data_gnt_o     = issue_ok && data_req_i && ahbl_hready;
    assign ahbl_htrans    = (issue_ok && data_req_i && be_legal) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbl_haddr     = {data_addr_i[ADDR_WIDTH-1:2], be_addr_lo};
    assign ahbl_hsize     = be_hsize;
    assign ahbl_hwrite    = data_we_i;
    assign ahbl_hburst    = HBURST_SINGLE;
    assign ahbl_hmastlock = 1'b0;
    assign ahbl_hprot     = HPROT_DATA;
    assign ahbl_hwdata    = wdata_q;

    always_comb begin
        state_d       = state_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        data_rvalid_o = 1'b0;
        data_err_o    = 1'b0;
        data_rdata_o  = '0;

        unique case (state_q)
            ST_DATA: begin
                if (ahbl_hresp) begin
                    // A single-cycle ERROR (hready already high) is still
                    // reported as an error rather than dropped.
                    if (ahbl_hready) begin
                        data_rvalid_o = 1'b1;
                        data_err_o    = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_ERR2;
                    end
                end else if (ahbl_hready) begin
                    data_rvalid_o = 1'b1;
                    data_rdata_o  = we_q ? '0 : ahbl_hrdata;
                    state_d       = ST_IDLE;
                end
            end
            ST_ERR2: begin
                if (ahbl_hready) begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_LERR: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                state_d       = ST_IDLE;
            end
            default: ;
        endcase

        // A grant in DATA coincides with its completion, so it overrides the
        // return to IDLE chosen above.
        if (data_gnt_o) begin
            if (be_legal) begin
                state_d = ST_DATA;
                wdata_d = data_wdata_i;
                we_d    = data_we_i;
            end else begin
                state_d = ST_LERR;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: doc/ibex_ahbl_bridge.md
# ibex_ahbl_bridge

- Converts the Ibex core's request/grant/rvalid data-memory interface into single AHB-Lite master transfers.
- Its outputs drive the `ahbl_*` inputs of the system AHB-Lite interconnect/decoder, so it sits directly upstream of that block.
- Handles byte-enable to HSIZE/HADDR translation, data-phase HWDATA alignment and the two-cycle AHB ERROR response.
- Address/data-phase pipelining is selectable at compile time.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32 (from `system_pkg`): address width.
- `DATA_WIDTH`, default 32 (from `system_pkg`): data width. Only 32 is supported.

Ports:
- `clk` in 1: sole clock.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `data_req_i` in 1: core request. Held, with `addr/we/be/wdata` stable, until `data_gnt_o`.
- `data_gnt_o` out 1: request accepted (AHB address phase sampled).
- `data_addr_i` in ADDR_WIDTH: word-aligned request address.
- `data_we_i` in 1: write request.
- `data_be_i` in 4: byte enables.
- `data_wdata_i` in DATA_WIDTH: write data, lane-aligned.
- `data_rvalid_o` out 1: response valid, one per grant.
- `data_rdata_o` out DATA_WIDTH: read data, valid with rvalid on reads.
- `data_err_o` out 1: error, valid with rvalid.
- `ahbl_haddr` out ADDR_WIDTH, `ahbl_hburst` out 3, `ahbl_hmastlock` out 1, `ahbl_hprot` out 4, `ahbl_hsize` out 3, `ahbl_htrans` out 2, `ahbl_hwdata` out DATA_WIDTH, `ahbl_hwrite` out 1: AHB-Lite master outputs.
- `ahbl_hrdata` in DATA_WIDTH, `ahbl_hready` in 1, `ahbl_hresp` in 1: AHB-Lite master inputs.

## Operation

FSM states:
- **IDLE**: no data phase outstanding.
- **DATA**: one bus data phase outstanding.
- **ERR2**: first ERROR cycle seen.
- **LERR**: local error pending.

Byte-enable decode (combinational):

| `data_be_i` | HSIZE | HADDR[1:0] |
|---|---|---|
| 1111 | WORD (3'b010) | 00 |
| 0011 | HALF (3'b001) | 00 |
| 1100 | HALF (3'b001) | 10 |
| 0001 | BYTE (3'b000) | 00 |
| 0010 | BYTE (3'b000) | 01 |
| 0100 | BYTE (3'b000) | 10 |
| 1000 | BYTE (3'b000) | 11 |

- Any other pattern is illegal.

Address phase:
- Address-phase signals are combinational from the `data_*` inputs.
- `ahbl_htrans` = NONSEQ (2'b10) when `data_req_i`, the BE pattern is legal, and the state permits issue. Otherwise IDLE (2'b00).
- Fixed outputs:
  - `hburst` = 3'b000 (SINGLE).
  - `hmastlock` = 0.
  - `hprot` = 4'b0011.

Grant:
- `data_gnt_o` = issue-permitted & `data_req_i` & `ahbl_hready`.
- On grant of a legal request: latch `we` and `wdata`, then go to DATA.
- On grant of an illegal BE: no bus transfer (HTRANS stays IDLE); go to LERR.

Data phase and responses:
- `ahbl_hwdata` is the wdata register, driven throughout the data phase.
- In DATA:
  - `hready`=1 and `hresp`=0: `data_rvalid_o`=1, `data_rdata_o`=`ahbl_hrdata` (combinational), `data_err_o`=0. Next state is IDLE, or DATA if a new grant occurs in the same cycle.
  - `hresp`=1 and `hready`=0: go to ERR2. HTRANS is forced IDLE and no grant is given.
- In ERR2:
  - `hready`=1: rvalid=1 and err=1; go to IDLE. No grant this cycle.
  - `hready`=0 (protocol violation): remain in ERR2.
- In LERR: rvalid=1 and err=1 for one cycle; go to IDLE. No grant this cycle.
- `data_rdata_o` = 0 whenever `data_rvalid_o`=0.

## Timing

- Reset values:
  - State = IDLE.
  - `htrans` = IDLE, `haddr` = 0, `hwdata` = 0, `hwrite` = 0, `hsize` = 0.
  - `gnt`, `rvalid`, `err` = 0.
  - `hburst` = 0, `hmastlock` = 0, `hprot` = 4'b0011.
- Latency:
  - Grant is in cycle N, at the earliest the cycle `req` rises with `hready`=1.
  - With a zero-wait slave, rvalid is in cycle N+1.
  - Each slave wait state adds one cycle.
- While `hready`=0 and `req` is held, address-phase outputs are stable (OBI guarantees stability).
- Reset mid-transfer: all state is dropped, with no rvalid for the outstanding grant.
- At most one outstanding grant at any time.

## Configuration

- `IBEX_AHBL_PIPELINE_EN` defined:
  - Issue is also permitted in DATA when `hresp`=0.
  - The next address phase overlaps the current data phase.
  - Back-to-back zero-wait transfers give one grant and one rvalid per cycle.
- Undefined:
  - Issue is permitted only in IDLE.
  - Each transfer costs at least 2 cycles, with an IDLE bus cycle between transfers.

## Structure

- `system_pkg` holds:
  - `ADDR_WIDTH`, `DATA_WIDTH`.
  - HTRANS encodings: IDLE, NONSEQ.
  - HSIZE constants: BYTE, HALF, WORD.
  - The FSM state enum.
- Sub-module `ibex_ahbl_be_decode` (combinational): inputs `be`; outputs `hsize`, `addr_lo[1:0]`, `legal`.

## Test plan

1. **Word read, zero-wait:** read, addr 0x2000_0010, be 1111, slave returns 0xDEADBEEF.
   - Expect HTRANS NONSEQ, HSIZE WORD, grant in N, rvalid in N+1, rdata 0xDEADBEEF, err 0.
2. **Byte write:** write, be 0100, addr 0x1000_0000, wdata 0x00AB0000.
   - Expect haddr 0x1000_0002, HSIZE BYTE, hwrite 1.
   - hwdata = 0x00AB0000 in the data phase.
3. **Two wait states:** slave holds `hready`=0 for 2 cycles.
   - Expect rvalid at N+3.
   - Address-phase outputs remain stable.
4. **ERROR response:** slave responds hresp=1/hready=0, then hresp=1/hready=1.
   - Expect HTRANS IDLE in both cycles, no grant, then rvalid with err=1.
5. **Illegal byte enable:** be 0110.
   - Expect grant, no NONSEQ on the bus, rvalid with err=1 the next cycle.
6. **Back-to-back zero-wait transfers:** 3 transfers.
   - With `IBEX_AHBL_PIPELINE_EN`: 3 rvalids in 3 consecutive cycles.
   - Without it: rvalids spaced 2 cycles apart.
   - Apply `rstn` low mid-burst: all outputs return to reset values immediately.
